// File: rtl/h264dequantise_pkg.sv
// Shared constants and helpers for the H.264 inverse quantiser:
// LevelScale tables, zigzag position classes and the QP decode.
package h264_pkg;

    localparam int ZW_DEF = 12;
    localparam int WW_DEF = 16;
    localparam logic [5:0] QP_MAX = 6'd51;

    typedef enum logic [1:0] {
        CLS_A = 2'd0,
        CLS_B = 2'd1,
        CLS_C = 2'd2
    } zig_cls_e;

    localparam logic [4:0] V0 [0:5] = '{5'd10, 5'd11, 5'd13, 5'd14, 5'd16, 5'd18};
    localparam logic [4:0] V1 [0:5] = '{5'd16, 5'd18, 5'd20, 5'd23, 5'd25, 5'd29};
    localparam logic [4:0] V2 [0:5] = '{5'd13, 5'd14, 5'd16, 5'd18, 5'd20, 5'd23};

    function automatic zig_cls_e zig_class(input logic [3:0] zig);
        zig_cls_e c;
        case (zig)
            4'd0, 4'd3, 4'd5, 4'd11:   c = CLS_A;
            4'd4, 4'd10, 4'd12, 4'd15: c = CLS_B;
            default:                   c = CLS_C;
        endcase
        return c;
    endfunction

    // Returns {e[3:0], m[2:0]}; QP above 51 decodes as 51.
    function automatic logic [6:0] qp_divmod6(input logic [5:0] qp);
        logic [5:0] q;
        logic [5:0] d;
        logic [5:0] r;
        q = (qp > QP_MAX) ? QP_MAX : qp;
        d = q / 6'd6;
        r = q % 6'd6;
        return {d[3:0], r[2:0]};
    endfunction

    function automatic logic [4:0] level_scale(input zig_cls_e cls, input logic [2:0] m);
        logic [2:0] mi;
        logic [4:0] v;
        mi = (m > 3'd5) ? 3'd5 : m;
        case (cls)
            CLS_A:   v = V0[mi];
            CLS_B:   v = V1[mi];
            CLS_C:   v = V2[mi];
            default: v = V2[mi];
        endcase
        return v;
    endfunction

endpackage

// File: rtl/h264dequantise_if.sv
// Coefficient stream between the quantiser side (master) and the
// inverse quantiser (slave).
interface h264dequantise_if #(
    parameter int ZW = 12,
    parameter int WW = 16
);
    logic                 ENABLE;
    logic                 DCCI;
    logic [5:0]           QP;
    logic signed [ZW-1:0] ZIN;
    logic                 VALID;
    logic                 DCCO;
    logic                 LAST;
    logic signed [WW-1:0] WOUT;

    modport master (
        output ENABLE, DCCI, QP, ZIN,
        input  VALID, DCCO, LAST, WOUT
    );

    modport slave (
        input  ENABLE, DCCI, QP, ZIN,
        output VALID, DCCO, LAST, WOUT
    );
endinterface

// File: rtl/h264dequantise.sv
// H.264 inverse quantiser: W = Z * LevelScale(QP%6, pos) << (QP/6),
// three registered stages, one coefficient per clock, saturating output.
module h264dequantise
    import h264_pkg::*;
#(
    parameter int ZW = ZW_DEF,
    parameter int WW = WW_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    h264dequantise_if.slave bus
);

    localparam int PW = ZW + 6;
    localparam int QW = PW + 8;

    logic [3:0]           r_zig;
    logic [2:0]           r_vld;
    logic [2:0]           r_dc;
    logic [2:0]           r_lst;
    logic signed [ZW-1:0] r_s1_z;
    logic [4:0]           r_s1_v;
    logic [3:0]           r_s1_e;
    logic signed [PW-1:0] r_s2_p;
    logic [3:0]           r_s2_e;
    logic signed [WW-1:0] r_wout;

    logic [6:0]           w_qpd;
    logic [3:0]           w_e;
    logic [2:0]           w_m;
    zig_cls_e             w_cls;
    logic [4:0]           w_v;
    logic                 w_last;
    logic signed [PW-1:0] w_z_ext;
    logic signed [PW-1:0] w_v_ext;
    logic signed [PW-1:0] w_p;
    logic signed [QW-1:0] w_p_ext;
    logic signed [QW-1:0] w_q_sh;
    logic signed [QW-1:0] w_q_rnd;
    logic signed [QW-1:0] w_q;
    logic signed [WW-1:0] w_sat;

    localparam logic signed [QW-1:0] SAT_HI = QW'(32767);
    localparam logic signed [QW-1:0] SAT_LO = -QW'(32768);

    // Stage-1 decode: position class, scale factor and block-end flag.
    always_comb begin
        w_qpd  = qp_divmod6(bus.QP);
        w_e    = w_qpd[6:3];
        w_m    = w_qpd[2:0];
        w_cls  = bus.DCCI ? CLS_A : zig_class(r_zig);
        w_v    = level_scale(w_cls, w_m);
        w_last = (r_zig == 4'd0) && !bus.DCCI;
    end

    // Stage-2 product, operands widened so the multiply is done at full width.
    always_comb begin
        w_z_ext = {{(PW-ZW){r_s1_z[ZW-1]}}, r_s1_z};
        w_v_ext = {{(PW-5){1'b0}}, r_s1_v};
        w_p     = w_z_ext * w_v_ext;
    end

    // Stage-3 shift, DC halving with round-toward-floor of (Q+1)/2, saturation.
    always_comb begin
        w_p_ext = {{(QW-PW){r_s2_p[PW-1]}}, r_s2_p};
        w_q_sh  = w_p_ext <<< r_s2_e;
        w_q_rnd = (w_q_sh + QW'(1)) >>> 1;
        if (r_dc[1]) begin
            w_q = w_q_rnd;
        end else begin
            w_q = w_q_sh;
        end
        if (w_q > SAT_HI) begin
            w_sat = {1'b0, {(WW-1){1'b1}}};
        end else if (w_q < SAT_LO) begin
            w_sat = {1'b1, {(WW-1){1'b0}}};
        end else begin
            w_sat = w_q[WW-1:0];
        end
    end

    // Position counter; a gap or a DC coefficient restarts the block at 15.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_zig <= 4'd15;
        end else if (!bus.ENABLE || bus.DCCI) begin
            r_zig <= 4'd15;
        end else begin
            r_zig <= r_zig - 4'd1;
        end
    end

    // Valid/DC/last shift registers advance every cycle alongside the data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_vld <= 3'd0;
            r_dc  <= 3'd0;
            r_lst <= 3'd0;
        end else begin
            r_vld <= {r_vld[1:0], bus.ENABLE};
            r_dc  <= {r_dc[1:0], bus.ENABLE & bus.DCCI};
            r_lst <= {r_lst[1:0], bus.ENABLE & w_last};
        end
    end

    // Data stages load only when their stage holds a valid coefficient.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_s1_z <= '0;
            r_s1_v <= 5'd0;
            r_s1_e <= 4'd0;
            r_s2_p <= '0;
            r_s2_e <= 4'd0;
            r_wout <= '0;
        end else begin
            if (bus.ENABLE) begin
                r_s1_z <= bus.ZIN;
                r_s1_v <= w_v;
                r_s1_e <= w_e;
            end
            if (r_vld[0]) begin
                r_s2_p <= w_p;
                r_s2_e <= r_s1_e;
            end
            if (r_vld[1]) begin
                r_wout <= w_sat;
            end
        end
    end

    assign bus.VALID = r_vld[2];
    assign bus.DCCO  = r_dc[2];
    assign bus.LAST  = r_lst[2];
    assign bus.WOUT  = r_wout;

endmodule

// File: tb/tb_h264dequantise.sv
// Randomised bench for h264dequantise: an arithmetic reference model feeds a
// queue of expected outputs that a negedge process compares every cycle.
module tb_h264dequantise;

    typedef struct {
        int due;
        int w;
        bit dc;
        bit last;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   mzig = 15;
    int   exp_w = 0;
    item_t q[$];

    int lsa [6] = '{10, 11, 13, 14, 16, 18};
    int lsb [6] = '{16, 18, 20, 23, 25, 29};
    int lsc [6] = '{13, 14, 16, 18, 20, 23};

    h264dequantise_if #(.ZW(12), .WW(16)) bus ();

    h264dequantise #(.ZW(12), .WW(16)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_val(int z, int zig, int qp, bit dc);
        int     qq;
        int     v;
        longint p;
        qq = (qp > 51) ? 51 : qp;
        if (dc || zig == 0 || zig == 3 || zig == 5 || zig == 11) v = lsa[qq % 6];
        else if (zig == 4 || zig == 10 || zig == 12 || zig == 15) v = lsb[qq % 6];
        else v = lsc[qq % 6];
        p = longint'(z) * longint'(v) * (longint'(1) << (qq / 6));
        if (dc) p = (p + 1) >>> 1;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                check("valid", int'(bus.VALID), 1);
                check("wout", int'(bus.WOUT), q[0].w);
                check("dcco", int'(bus.DCCO), int'(q[0].dc));
                check("last", int'(bus.LAST), int'(q[0].last));
                exp_w = q[0].w;
                void'(q.pop_front());
            end else begin
                check("idle_valid", int'(bus.VALID), 0);
                check("idle_last", int'(bus.LAST), 0);
                check("hold_wout", int'(bus.WOUT), exp_w);
            end
        end
    end

    task automatic drive(bit en, bit dc, int qp, int z);
        item_t it;
        @(negedge clk);
        #1;
        bus.ENABLE = en;
        bus.DCCI   = en & dc;
        bus.QP     = qp[5:0];
        bus.ZIN    = z[11:0];
        if (en) begin
            it.due  = cyc + 3;
            it.w    = exp_val(z, mzig, qp, dc);
            it.dc   = dc;
            it.last = (mzig == 0) && !dc;
            q.push_back(it);
        end
        mzig = (!en || dc) ? 15 : (mzig + 15) % 16;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.ENABLE = 1'b0;
        bus.DCCI   = 1'b0;
        bus.QP     = 6'd0;
        bus.ZIN    = 12'sd0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(bus.VALID), 0);
        check("rst_dcco", int'(bus.DCCO), 0);
        check("rst_last", int'(bus.LAST), 0);
        check("rst_wout", int'(bus.WOUT), 0);
        #1 rst = 1'b0;

        // Hand-computed values pin the reference model.
        check("pin_unity_b", exp_val(1, 15, 0, 1'b0), 16);
        check("pin_unity_a", exp_val(1, 11, 0, 1'b0), 10);
        check("pin_shift", exp_val(-3, 0, 28, 1'b0), -768);
        check("pin_dc_pos", exp_val(5, 7, 12, 1'b1), 100);
        check("pin_dc_neg", exp_val(-5, 7, 12, 1'b1), -100);
        check("pin_sat_hi", exp_val(2047, 15, 51, 1'b0), 32767);
        check("pin_sat_lo", exp_val(-2048, 15, 51, 1'b0), -32768);
        check("pin_qp_clamp", exp_val(1, 1, 63, 1'b0), 18 * 256);

        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 0, 1);
        idle(4);
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 28, (i == 15) ? -3 : 0);
        idle(4);
        drive(1'b1, 1'b1, 12, 5);
        drive(1'b1, 1'b1, 12, -5);
        idle(4);
        drive(1'b1, 1'b0, 51, 2047);
        idle(1);
        drive(1'b1, 1'b0, 51, -2048);
        idle(4);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 0, 1);
        idle(2);
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 0, 1);
        idle(4);

        // Reset with two coefficients still in the pipeline.
        drive(1'b1, 1'b0, 20, 300);
        drive(1'b1, 1'b0, 20, -7);
        @(posedge clk);
        #2;
        rst        = 1'b1;
        bus.ENABLE = 1'b0;
        bus.DCCI   = 1'b0;
        #1;
        check("async_valid", int'(bus.VALID), 0);
        check("async_wout", int'(bus.WOUT), 0);
        q.delete();
        mzig  = 15;
        exp_w = 0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        idle(4);
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 0, 1);

        for (int i = 0; i < 600; i++) begin
            int z;
            int sel;
            sel = int'($urandom_range(0, 15));
            if (sel == 0) z = 2047;
            else if (sel == 1) z = -2048;
            else z = int'($urandom_range(0, 4095)) - 2048;
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 63)), z);
        end
        idle(6);
        check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
